// File: rtl/seq_multiplier.sv
// Shift-add sequential multiplier: WIDTH iterations per product, start/busy/done handshake.
// Define SIGNED_MULT_EN to treat operands as two's-complement (sign-magnitude wrap around the core).
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH:0]   r_acc;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_prod_lo;
  logic [WIDTH-1:0]   r_prod_hi;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH:0]   w_step;
  logic               w_last;
  logic [2*WIDTH-1:0] w_result;
  logic [WIDTH-1:0]   w_op_a;
  logic [WIDTH-1:0]   w_op_b;

`ifdef SIGNED_MULT_EN
  logic r_neg;

  // Magnitude of 0x8000 is 0x8000, still correct when read as unsigned.
  assign w_op_a   = a[WIDTH-1] ? -a : a;
  assign w_op_b   = b[WIDTH-1] ? -b : b;
  assign w_result = r_neg ? -w_step[2*WIDTH-1:0] : w_step[2*WIDTH-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_neg <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_neg <= a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  assign w_op_a   = a;
  assign w_op_b   = b;
  assign w_result = w_step[2*WIDTH-1:0];
`endif

  // Carry bit r_acc[2*WIDTH] is zero after every shift, so the add never loses a bit.
  assign w_sum  = r_acc[2*WIDTH:WIDTH] + {1'b0, r_mcand};
  assign w_step = r_acc[0] ? {1'b0, w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH:1]};
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:  busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_prod_lo <= '0;
      r_prod_hi <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= w_op_a;
            r_acc   <= {{(WIDTH+1){1'b0}}, w_op_b};
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_prod_lo <= w_result[WIDTH-1:0];
            r_prod_hi <= w_result[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign product_lo = r_prod_lo;
  assign product_hi = r_prod_hi;

endmodule
